// File: rtl/core_csrs_pkg.sv
// Shared CSR addresses, bit positions and interrupt cause codes for the
// machine-mode CSR file.
package core_csrs_pkg;

  localparam logic [11:0] CSR_ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_ADDR_MHARTID       = 12'hF14;
  localparam logic [11:0] CSR_ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_ADDR_MISA          = 12'h301;
  localparam logic [11:0] CSR_ADDR_MIE           = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_ADDR_MIP           = 12'h344;
  localparam logic [11:0] CSR_ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET      = 12'hB02;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MSIE     = 3;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIE_MEIE     = 11;

  localparam logic [6:0] INT_CAUSE_MEI = 7'd11;
  localparam logic [6:0] INT_CAUSE_MSI = 7'd3;
  localparam logic [6:0] INT_CAUSE_MTI = 7'd7;

  localparam int unsigned CSR_COUNT_CY = 0;
  localparam int unsigned CSR_COUNT_IR = 2;

  typedef enum logic [1:0] {
    CSR_OP_NONE,
    CSR_OP_WR,
    CSR_OP_SET,
    CSR_OP_CLR
  } csr_op_e;

  function automatic csr_op_e csr_op(input logic wr, input logic set, input logic clr);
    if (wr)       return CSR_OP_WR;
    else if (set) return CSR_OP_SET;
    else if (clr) return CSR_OP_CLR;
    else          return CSR_OP_NONE;
  endfunction

endpackage

// File: rtl/core_csrs_counter.sv
// Free-running counter with inhibit, increment enable and a write port that
// overrides the increment in the same cycle.
module core_csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         i_inhibit,
  input  logic         i_inc,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_count;

  always_ff @(posedge g_clk) begin
    if (!g_resetn)                r_count <= '0;
    else if (i_wr)                r_count <= i_wdata;
    else if (i_inc && !i_inhibit) r_count <= r_count + W'(1);
  end

  assign o_value = r_count;

endmodule

// File: rtl/core_csrs.sv
// Machine-mode CSR file: CSR access port, trap/MRET state, counters and
// interrupt request generation for the writeback stage.
module core_csrs
  import core_csrs_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_8000_0000,
  parameter logic [XLEN-1:0] MISA_VALUE  = 64'h8000_0000_0000_0100,
  parameter logic [XLEN-1:0] MHARTID     = '0
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            csr_en,
  input  logic            csr_wr,
  input  logic            csr_wr_set,
  input  logic            csr_wr_clr,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_error,
  output logic [XLEN-1:0] mtvec_base,
  input  logic            trap_cpu,
  input  logic            trap_int,
  input  logic [6:0]      trap_cause,
  input  logic [XLEN-1:0] trap_mtval,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            exec_mret,
  input  logic            instr_ret,
  output logic [XLEN-1:0] mepc_out,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_ti,
  output logic            int_pending,
  output logic [6:0]      int_cause,
  output logic [XLEN-1:0] int_tvec
);

  localparam logic [XLEN-1:0] MIE_MASK = XLEN'((1 << MIE_MEIE) | (1 << MIE_MTIE) | (1 << MIE_MSIE));
  localparam logic [XLEN-1:0] MCI_MASK = XLEN'((1 << CSR_COUNT_CY) | (1 << CSR_COUNT_IR));

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mcountinhibit;

  logic [XLEN-1:0] w_mcycle;
  logic [XLEN-1:0] w_minstret;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_wval;
  logic [XLEN-1:0] w_base;
  logic            w_mapped;
  logic            w_err;
  logic            w_wen;
  logic            w_trap;
  logic [2:0]      w_pend;
  logic [6:0]      w_int_cause;
  csr_op_e         w_op;

  always_comb begin
    w_mstatus               = '0;
    w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
    w_mip                   = '0;
    w_mip[MIE_MEIE]         = irq_ext;
    w_mip[MIE_MTIE]         = irq_ti;
    w_mip[MIE_MSIE]         = irq_sw;
  end

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (csr_addr)
      CSR_ADDR_MVENDORID,
      CSR_ADDR_MARCHID,
      CSR_ADDR_MIMPID:        w_rdata = '0;
      CSR_ADDR_MHARTID:       w_rdata = MHARTID;
      CSR_ADDR_MISA:          w_rdata = MISA_VALUE;
      CSR_ADDR_MSTATUS:       w_rdata = w_mstatus;
      CSR_ADDR_MIE:           w_rdata = r_mie;
      CSR_ADDR_MTVEC:         w_rdata = r_mtvec;
      CSR_ADDR_MCOUNTINHIBIT: w_rdata = r_mcountinhibit;
      CSR_ADDR_MSCRATCH:      w_rdata = r_mscratch;
      CSR_ADDR_MEPC:          w_rdata = r_mepc;
      CSR_ADDR_MCAUSE:        w_rdata = r_mcause;
      CSR_ADDR_MTVAL:         w_rdata = r_mtval;
      CSR_ADDR_MIP:           w_rdata = w_mip;
      CSR_ADDR_MCYCLE:        w_rdata = w_mcycle;
      CSR_ADDR_MINSTRET:      w_rdata = w_minstret;
      default:                w_mapped = 1'b0;
    endcase
  end

  // misa is read-only even though it sits in the read/write address range.
  always_comb begin
    w_op  = csr_op(csr_wr, csr_wr_set, csr_wr_clr);
    w_err = csr_en && (!w_mapped || ((w_op != CSR_OP_NONE) &&
            ((csr_addr[11:10] == 2'b11) || (csr_addr == CSR_ADDR_MISA))));
    w_wen = csr_en && (w_op != CSR_OP_NONE) && !w_err;
    case (w_op)
      CSR_OP_SET: w_wval = w_rdata | csr_wdata;
      CSR_OP_CLR: w_wval = w_rdata & ~csr_wdata;
      default:    w_wval = csr_wdata;
    endcase
  end

  assign w_trap = trap_cpu | trap_int;

  // Trap beats MRET beats CSR write on the registers they share.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else if (w_trap) begin
      r_mepc         <= trap_pc & ~XLEN'(3);
      r_mcause       <= {trap_int, {(XLEN-8){1'b0}}, trap_cause};
      r_mtval        <= trap_mtval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else begin
      if (w_wen && csr_addr == CSR_ADDR_MEPC)   r_mepc   <= w_wval & ~XLEN'(3);
      if (w_wen && csr_addr == CSR_ADDR_MCAUSE) r_mcause <= w_wval;
      if (w_wen && csr_addr == CSR_ADDR_MTVAL)  r_mtval  <= w_wval;
      if (exec_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wen && csr_addr == CSR_ADDR_MSTATUS) begin
        r_mstatus_mie  <= w_wval[MSTATUS_MIE];
        r_mstatus_mpie <= w_wval[MSTATUS_MPIE];
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_mie           <= '0;
      r_mtvec         <= MTVEC_RESET;
      r_mscratch      <= '0;
      r_mcountinhibit <= '0;
    end else if (w_wen) begin
      case (csr_addr)
        CSR_ADDR_MIE:           r_mie           <= w_wval & MIE_MASK;
        CSR_ADDR_MTVEC:         r_mtvec         <= w_wval & ~XLEN'(2);
        CSR_ADDR_MSCRATCH:      r_mscratch      <= w_wval;
        CSR_ADDR_MCOUNTINHIBIT: r_mcountinhibit <= w_wval & MCI_MASK;
        default: ;
      endcase
    end
  end

  core_csr_counter #(.W(XLEN)) u_mcycle (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .i_inhibit (r_mcountinhibit[CSR_COUNT_CY]),
    .i_inc     (1'b1),
    .i_wr      (w_wen && csr_addr == CSR_ADDR_MCYCLE),
    .i_wdata   (w_wval),
    .o_value   (w_mcycle)
  );

  core_csr_counter #(.W(XLEN)) u_minstret (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .i_inhibit (r_mcountinhibit[CSR_COUNT_IR]),
    .i_inc     (instr_ret),
    .i_wr      (w_wen && csr_addr == CSR_ADDR_MINSTRET),
    .i_wdata   (w_wval),
    .o_value   (w_minstret)
  );

  always_comb begin
    w_pend = {r_mie[MIE_MEIE] & irq_ext, r_mie[MIE_MTIE] & irq_ti, r_mie[MIE_MSIE] & irq_sw};
    if (w_pend[2])      w_int_cause = INT_CAUSE_MEI;
    else if (w_pend[0]) w_int_cause = INT_CAUSE_MSI;
    else if (w_pend[1]) w_int_cause = INT_CAUSE_MTI;
    else                w_int_cause = '0;
  end

  assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
  assign mtvec_base  = w_base;
  assign int_pending = r_mstatus_mie && (|w_pend);
  assign int_cause   = w_int_cause;
  assign int_tvec    = w_base + (r_mtvec[0] ? (XLEN'(w_int_cause) << 2) : '0);
  assign csr_rdata   = w_rdata;
  assign csr_error   = w_err;
  assign mepc_out    = r_mepc;

endmodule

// File: tb/tb_core_csrs.sv
// Bench for core_csrs: directed table, hand-written corner sequences and a
// randomized run checked against a behavioural model of the CSR file.
module tb_core_csrs;

  localparam logic [11:0] A_MVENDORID = 12'hF11, A_MHARTID = 12'hF14;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304;
  localparam logic [11:0] A_MTVEC = 12'h305, A_MCI = 12'h320, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  localparam logic [11:0] A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [63:0] MISA_V = 64'h8000_0000_0000_0100;
  localparam logic [11:0] ADDRS [18] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300,
    12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
    12'hB00, 12'hB02, 12'h7C0, 12'h123};

  logic g_clk = 1'b0, g_resetn;
  logic csr_en, csr_wr, csr_wr_set, csr_wr_clr, csr_error;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata, mtvec_base, trap_mtval, trap_pc, mepc_out, int_tvec;
  logic trap_cpu, trap_int, exec_mret, instr_ret, irq_ext, irq_sw, irq_ti, int_pending;
  logic [6:0] trap_cause, int_cause;

  int n_vec = 0;
  int n_err = 0;

  core_csrs dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .csr_en(csr_en), .csr_wr(csr_wr),
    .csr_wr_set(csr_wr_set), .csr_wr_clr(csr_wr_clr), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_error(csr_error),
    .mtvec_base(mtvec_base), .trap_cpu(trap_cpu), .trap_int(trap_int),
    .trap_cause(trap_cause), .trap_mtval(trap_mtval), .trap_pc(trap_pc),
    .exec_mret(exec_mret), .instr_ret(instr_ret), .mepc_out(mepc_out),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_ti(irq_ti), .int_pending(int_pending),
    .int_cause(int_cause), .int_tvec(int_tvec)
  );

  always #5 g_clk = ~g_clk;

  // Reference model state
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mci, m_mcycle, m_minstret;

  function automatic bit m_mapped(input logic [11:0] a);
    foreach (ADDRS[i]) if (i < 16 && ADDRS[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      A_MHARTID: return 64'd0;
      A_MISA:    return MISA_V;
      A_MSTATUS: return m_mstatus;
      A_MIE:     return m_mie;
      A_MTVEC:   return m_mtvec;
      A_MCI:     return m_mci;
      A_MSCRATCH: return m_mscratch;
      A_MEPC:    return m_mepc;
      A_MCAUSE:  return m_mcause;
      A_MTVAL:   return m_mtval;
      A_MIP:     return (64'(irq_ext) << 11) | (64'(irq_ti) << 7) | (64'(irq_sw) << 3);
      A_MCYCLE:  return m_mcycle;
      A_MINSTRET: return m_minstret;
      default:   return 64'd0;
    endcase
  endfunction

  function automatic bit m_error();
    bit anyw = csr_wr | csr_wr_set | csr_wr_clr;
    return csr_en && (!m_mapped(csr_addr) ||
           (anyw && (csr_addr >= 12'hC00 || csr_addr == A_MISA)));
  endfunction

  function automatic logic [6:0] m_cause();
    logic [63:0] pend = m_mie & m_read(A_MIP);
    if (pend[11]) return 7'd11;
    if (pend[3])  return 7'd3;
    if (pend[7])  return 7'd7;
    return 7'd0;
  endfunction

  task automatic m_tick();
    logic [63:0] nv, ncy, nir, base_old;
    bit wen, trap;
    if (!g_resetn) begin
      m_mstatus = 0; m_mie = 0; m_mtvec = 64'h8000_0000; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_mci = 0; m_mcycle = 0; m_minstret = 0;
      return;
    end
    base_old = m_read(csr_addr);
    wen  = csr_en && (csr_wr | csr_wr_set | csr_wr_clr) && !m_error();
    nv   = csr_wr ? csr_wdata : csr_wr_set ? (base_old | csr_wdata) : (base_old & ~csr_wdata);
    trap = trap_cpu | trap_int;
    ncy  = m_mci[0] ? m_mcycle : m_mcycle + 1;
    nir  = (instr_ret && !m_mci[2]) ? m_minstret + 1 : m_minstret;
    if (wen) case (csr_addr)
      A_MSTATUS:  if (!trap && !exec_mret) m_mstatus = nv & 64'h88;
      A_MIE:      m_mie = nv & 64'h888;
      A_MTVEC:    m_mtvec = nv & ~64'd2;
      A_MSCRATCH: m_mscratch = nv;
      A_MEPC:     if (!trap) m_mepc = nv & ~64'd3;
      A_MCAUSE:   if (!trap) m_mcause = nv;
      A_MTVAL:    if (!trap) m_mtval = nv;
      A_MCI:      m_mci = nv & 64'h5;
      A_MCYCLE:   ncy = nv;
      A_MINSTRET: nir = nv;
      default: ;
    endcase
    if (trap) begin
      m_mepc    = trap_pc & ~64'd3;
      m_mcause  = (64'(trap_int) << 63) | 64'(trap_cause);
      m_mtval   = trap_mtval;
      m_mstatus = m_mstatus[3] ? 64'h80 : 64'h0;
    end else if (exec_mret) begin
      m_mstatus = 64'h80 | (m_mstatus[7] ? 64'h8 : 64'h0);
    end
    m_mcycle = ncy;
    m_minstret = nir;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    logic [63:0] base;
    @(negedge g_clk);
    base = m_mtvec & ~64'd3;
    chk("m_rdata", csr_rdata, m_read(csr_addr));
    if (csr_en) chk("m_error", 64'(csr_error), 64'(m_error()));
    chk("m_mtvec_base", mtvec_base, base);
    chk("m_mepc_out", mepc_out, m_mepc);
    chk("m_int_pending", 64'(int_pending), 64'(m_mstatus[3] && ((m_mie & m_read(A_MIP)) != 0)));
    chk("m_int_cause", 64'(int_cause), 64'(m_cause()));
    chk("m_int_tvec", int_tvec, base + (m_mtvec[0] ? 64'(m_cause()) * 4 : 64'd0));
  endtask

  task automatic tick();
    @(posedge g_clk);
    m_tick();
    #1;
  endtask

  task automatic idle();
    csr_en = 0; csr_wr = 0; csr_wr_set = 0; csr_wr_clr = 0; csr_addr = 0; csr_wdata = 0;
    trap_cpu = 0; trap_int = 0; trap_cause = 0; trap_mtval = 0; trap_pc = 0;
    exec_mret = 0; instr_ret = 0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [63:0] e);
    csr_en = 1; csr_addr = a; settle(); chk(nm, csr_rdata, e); tick(); csr_en = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_en = 1; csr_wr = 1; csr_addr = a; csr_wdata = d; settle(); tick();
    csr_en = 0; csr_wr = 0;
  endtask

  typedef struct {
    logic [1:0]  op;   // 0 read, 1 write, 2 set, 3 clear
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t V(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d,
                             input logic [63:0] e, input logic er);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = d; v.exp_rd = e; v.exp_err = er;
    return v;
  endfunction

  initial begin
    idle();
    irq_ext = 0; irq_sw = 0; irq_ti = 0;
    g_resetn = 0;
    tick(); tick();
    settle();
    chk("rst_mtvec_base", mtvec_base, 64'h8000_0000);
    chk("rst_int_pending", 64'(int_pending), 64'd0);
    chk("rst_mepc_out", mepc_out, 64'd0);
    tick();
    g_resetn = 1;

    tbl.push_back(V(0, A_MCYCLE, 0, 64'd0, 0));
    tbl.push_back(V(0, A_MCYCLE, 0, 64'd1, 0));
    tbl.push_back(V(0, A_MCYCLE, 0, 64'd2, 0));
    tbl.push_back(V(0, A_MTVEC, 0, 64'h8000_0000, 0));
    tbl.push_back(V(0, A_MSTATUS, 0, 64'd0, 0));
    tbl.push_back(V(0, A_MISA, 0, MISA_V, 0));
    tbl.push_back(V(0, A_MHARTID, 0, 64'd0, 0));
    tbl.push_back(V(1, A_MSCRATCH, 64'hDEAD_BEEF, 64'd0, 0));
    tbl.push_back(V(2, A_MSCRATCH, 64'hF0, 64'hDEAD_BEEF, 0));
    tbl.push_back(V(3, A_MSCRATCH, 64'h0F, 64'hDEAD_BEFF, 0));
    tbl.push_back(V(0, A_MSCRATCH, 0, 64'hDEAD_BEF0, 0));
    tbl.push_back(V(1, A_MISA, 64'd0, MISA_V, 1));
    tbl.push_back(V(1, 12'h7C0, 64'd1, 64'd0, 1));
    tbl.push_back(V(0, A_MISA, 0, MISA_V, 0));
    tbl.push_back(V(1, A_MIP, 64'hFFF, 64'd0, 0));
    tbl.push_back(V(0, A_MIP, 0, 64'd0, 0));
    tbl.push_back(V(1, A_MVENDORID, 64'd7, 64'd0, 1));
    tbl.push_back(V(1, A_MTVEC, 64'h1003, 64'h8000_0000, 0));
    tbl.push_back(V(0, A_MTVEC, 0, 64'h1001, 0));
    tbl.push_back(V(1, A_MEPC, 64'h123, 64'd0, 0));
    tbl.push_back(V(0, A_MEPC, 0, 64'h120, 0));
    tbl.push_back(V(1, A_MSTATUS, '1, 64'd0, 0));
    tbl.push_back(V(0, A_MSTATUS, 0, 64'h88, 0));
    tbl.push_back(V(1, A_MIE, '1, 64'd0, 0));
    tbl.push_back(V(0, A_MIE, 0, 64'h888, 0));
    tbl.push_back(V(0, 12'h7C0, 0, 64'd0, 1));
    tbl.push_back(V(1, A_MCI, 64'hFF, 64'd0, 0));
    tbl.push_back(V(1, A_MCI, 64'd0, 64'd5, 0));

    foreach (tbl[i]) begin
      csr_en = 1; csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
      csr_wr = (tbl[i].op == 1); csr_wr_set = (tbl[i].op == 2); csr_wr_clr = (tbl[i].op == 3);
      settle();
      chk($sformatf("tbl%0d_rdata", i), csr_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_error", i), 64'(csr_error), 64'(tbl[i].exp_err));
      tick();
    end
    idle();

    // Timer interrupt, then taken as a trap
    wr(A_MSTATUS, 64'h8);
    wr(A_MIE, 64'h80);
    irq_ti = 1;
    settle();
    chk("mti_pending", 64'(int_pending), 64'd1);
    chk("mti_cause", 64'(int_cause), 64'd7);
    chk("mti_tvec", int_tvec, 64'h101C);
    tick();
    trap_int = 1; trap_cause = 7; trap_pc = 64'h1006;
    settle(); tick(); idle();
    rd("trap_mepc", A_MEPC, 64'h1004);
    chk("trap_mepc_out", mepc_out, 64'h1004);
    rd("trap_mcause", A_MCAUSE, 64'h8000_0000_0000_0007);
    rd("trap_mstatus", A_MSTATUS, 64'h80);
    chk("trap_no_pending", 64'(int_pending), 64'd0);

    // Vectored mode with MEI and MTI both pending, then MRET
    wr(A_MTVEC, 64'h1001);
    wr(A_MIE, 64'h880);
    irq_ext = 1;
    settle();
    chk("vec_cause", 64'(int_cause), 64'd11);
    chk("vec_tvec", int_tvec, 64'h102C);
    chk("vec_masked", 64'(int_pending), 64'd0);
    tick();
    exec_mret = 1; settle(); tick(); exec_mret = 0;
    rd("mret_mstatus", A_MSTATUS, 64'h88);
    chk("mret_pending", 64'(int_pending), 64'd1);

    // Trap collides with a mepc write; MRET collides with an mstatus write
    trap_cpu = 1; trap_cause = 2; trap_pc = 64'h2000; trap_mtval = 64'hABC;
    csr_en = 1; csr_wr = 1; csr_addr = A_MEPC; csr_wdata = 64'h5550;
    settle(); tick(); idle();
    rd("coll_mepc", A_MEPC, 64'h2000);
    rd("coll_mtval", A_MTVAL, 64'hABC);
    rd("coll_mcause", A_MCAUSE, 64'd2);
    exec_mret = 1; wr(A_MSTATUS, 64'd0); exec_mret = 0;
    rd("coll_mstatus", A_MSTATUS, 64'h88);
    irq_ext = 0; irq_ti = 0;

    // Counter wrap, write-over-increment, inhibit
    wr(A_MINSTRET, '1);
    instr_ret = 1; settle(); tick(); instr_ret = 0;
    rd("ir_wrap", A_MINSTRET, 64'd0);
    instr_ret = 1; wr(A_MINSTRET, 64'd5); instr_ret = 0;
    rd("ir_wr_wins", A_MINSTRET, 64'd5);
    wr(A_MCI, 64'd5);
    wr(A_MCYCLE, 64'd100);
    instr_ret = 1;
    rd("cy_frozen0", A_MCYCLE, 64'd100);
    rd("ir_frozen0", A_MINSTRET, 64'd5);
    rd("cy_frozen1", A_MCYCLE, 64'd100);
    rd("ir_frozen1", A_MINSTRET, 64'd5);
    instr_ret = 0;
    wr(A_MCI, 64'd0);

    // Reset while a write is in flight
    g_resetn = 0;
    wr(A_MSCRATCH, 64'h55);
    g_resetn = 1;
    rd("rst_mscratch", A_MSCRATCH, 64'd0);
    rd("rst_mtvec", A_MTVEC, 64'h8000_0000);
    rd("rst_mstatus", A_MSTATUS, 64'd0);

    for (int i = 0; i < 2000; i++) begin
      int op, t;
      g_resetn   = ($urandom_range(99) != 0);
      csr_en     = $urandom_range(1);
      op         = $urandom_range(3);
      csr_wr     = (op == 1); csr_wr_set = (op == 2); csr_wr_clr = (op == 3);
      csr_addr   = ADDRS[$urandom_range(17)];
      csr_wdata  = {$urandom, $urandom};
      t          = $urandom_range(15);
      trap_cpu   = (t == 0); trap_int = (t == 1);
      trap_cause = 7'($urandom_range(127));
      trap_pc    = {$urandom, $urandom};
      trap_mtval = {$urandom, $urandom};
      exec_mret  = ($urandom_range(11) == 0);
      instr_ret  = $urandom_range(1);
      if ($urandom_range(7) == 0) irq_ext = $urandom_range(1);
      if ($urandom_range(7) == 0) irq_sw  = $urandom_range(1);
      if ($urandom_range(7) == 0) irq_ti  = $urandom_range(1);
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
